// File: rtl/uart_tx_queue.sv
// Byte FIFO plus cycle-counted pacer feeding the uart transmit side.
// One byte per frame slot; tx_dte is held for DTE_CYCLES at the start of each slot.
module uart_tx_queue #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned FRAME_CYCLES = 114584,
  parameter int unsigned DTE_CYCLES   = 652
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               tx_data,
  output logic                     tx_dte,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(FRAME_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    GAP
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [SW-1:0]   slot_cnt;
  logic            pop_c;
  logic            wr_ok_c;
  logic [CW-1:0]   count_nxt_c;

  // Full is judged on the pre-edge occupancy, so a write while full is dropped even on a pop edge.
  assign wr_ok_c     = wr_en && !full;
  assign count_nxt_c = count + CW'(wr_ok_c) - CW'(pop_c);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Slot sequencing: pop on leaving IDLE and at the end of each slot while data is waiting.
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop_c     = 1'b1;
          state_nxt = STROBE;
        end
      end
      STROBE: begin
        if (slot_cnt == SW'(DTE_CYCLES)) state_nxt = GAP;
      end
      GAP: begin
        if (slot_cnt == SW'(FRAME_CYCLES)) begin
          if (!empty) begin
            pop_c     = 1'b1;
            state_nxt = STROBE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage array needs no reset; pointers and occupancy decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      tx_data  <= 8'h00;
      tx_dte   <= 1'b0;
      busy     <= 1'b0;
      slot_cnt <= '0;
    end else begin
      if (wr_ok_c) wptr <= wptr + AW'(1);
      if (wr_en && full) overflow <= 1'b1;
      count <= count_nxt_c;
      empty <= (count_nxt_c == CW'(0));
      full  <= (count_nxt_c == CW'(DEPTH));
      if (pop_c) begin
        tx_data  <= mem[rptr];
        rptr     <= rptr + AW'(1);
        slot_cnt <= SW'(1);
      end else if (state_nxt == IDLE) begin
        slot_cnt <= '0;
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
      tx_dte <= (state_nxt == STROBE);
      busy   <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with DEPTH=4, FRAME_CYCLES=20, DTE_CYCLES=4.
module tb_uart_tx_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full, empty, overflow, tx_dte, busy;
  logic [2:0] count;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;

  uart_tx_queue #(.DEPTH(4), .FRAME_CYCLES(20), .DTE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_data(tx_data), .tx_dte(tx_dte), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int         rise_t [12];
  logic [7:0] rise_d [12];
  int         n_rise;
  int         dte_hi;
  int         max_cnt;
  logic       prev_dte;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    tick(); tick();
    reset = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_dte", 32'(tx_dte), 0);
    chk("rst_busy", 32'(busy), 0);

    // 1: single byte, latency and strobe/slot widths
    wr_data = 8'h41; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("t1_count_after_wr", 32'(count), 1);
    chk("t1_dte_not_yet", 32'(tx_dte), 0);
    tick();
    chk("t1_dte_rise", 32'(tx_dte), 1);
    chk("t1_data", 32'(tx_data), 32'h41);
    chk("t1_empty_after_pop", 32'(empty), 1);
    chk("t1_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_dte_held", 32'(tx_dte), 1);
    end
    tick();
    chk("t1_dte_fall", 32'(tx_dte), 0);
    for (int i = 0; i < 15; i++) tick();
    chk("t1_busy_last", 32'(busy), 1);
    tick();
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_data_hold", 32'(tx_data), 32'h41);

    // 2: back-to-back 41,42,43
    n_rise = 0; dte_hi = 0; prev_dte = tx_dte;
    wr_data = 8'h41; wr_en = 1'b1;
    tick();
    for (int t = 1; t <= 70; t++) begin
      if (t == 1) wr_data = 8'h42;
      else if (t == 2) wr_data = 8'h43;
      else wr_en = 1'b0;
      tick();
      if (tx_dte) dte_hi++;
      if (tx_dte && !prev_dte && n_rise < 12) begin
        rise_t[n_rise] = t; rise_d[n_rise] = tx_data; n_rise++;
      end
      prev_dte = tx_dte;
    end
    chk("t2_n_rise", 32'(n_rise), 3);
    chk("t2_first_rise", 32'(rise_t[0]), 1);
    chk("t2_gap01", 32'(rise_t[1] - rise_t[0]), 20);
    chk("t2_gap12", 32'(rise_t[2] - rise_t[1]), 20);
    chk("t2_data0", 32'(rise_d[0]), 32'h41);
    chk("t2_data1", 32'(rise_d[1]), 32'h42);
    chk("t2_data2", 32'(rise_d[2]), 32'h43);
    chk("t2_dte_cycles", 32'(dte_hi), 12);
    chk("t2_idle", 32'(busy), 0);

    // 3: six writes while a byte is in flight
    wr_data = 8'h50; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    chk("t3_inflight", 32'(tx_data), 32'h50);
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'(8'h51 + i); wr_en = 1'b1;
      tick();
      if (i == 3) begin
        chk("t3_count4", 32'(count), 4);
        chk("t3_full", 32'(full), 1);
        chk("t3_no_ovf_yet", 32'(overflow), 0);
      end
    end
    wr_en = 1'b0;
    chk("t3_count_after", 32'(count), 4);
    chk("t3_overflow", 32'(overflow), 1);
    for (int i = 0; i < 13; i++) tick();
    chk("t3_ovf_sticky", 32'(overflow), 1);
    chk("t3_still_full", 32'(count), 4);

    // 4: write on the pop edge while full is dropped
    wr_data = 8'h99; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("t4_count", 32'(count), 3);
    chk("t4_full", 32'(full), 0);
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_pop_data", 32'(tx_data), 32'h51);
    chk("t4_pop_dte", 32'(tx_dte), 1);

    // 5: reset mid-strobe
    tick();
    chk("t5_in_strobe", 32'(tx_dte), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_dte", 32'(tx_dte), 0);
    chk("t5_data", 32'(tx_data), 0);
    chk("t5_count", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_overflow", 32'(overflow), 0);
    for (int i = 0; i < 5; i++) tick();
    chk("t5_stays_idle", 32'(busy), 0);
    chk("t5_dte_low", 32'(tx_dte), 0);

    // 6: ten paced writes force pointer wrap
    n_rise = 0; max_cnt = 0; prev_dte = tx_dte;
    for (int t = 0; t < 230; t++) begin
      wr_en   = (t % 20 == 0) && (t < 200);
      wr_data = 8'(8'h60 + t / 20);
      tick();
      if (32'(count) > max_cnt) max_cnt = 32'(count);
      if (tx_dte && !prev_dte && n_rise < 12) begin
        rise_t[n_rise] = t; rise_d[n_rise] = tx_data; n_rise++;
      end
      prev_dte = tx_dte;
    end
    wr_en = 1'b0;
    chk("t6_n_rise", 32'(n_rise), 10);
    chk("t6_max_count", 32'(max_cnt), 1);
    for (int i = 0; i < 10; i++) begin
      if (i < n_rise) chk("t6_data", 32'(rise_d[i]), 32'(8'h60 + i));
    end
    chk("t6_empty", 32'(empty), 1);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_last_data", 32'(tx_data), 32'h69);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
